// File: rtl/vmul_pkg.sv
// Shared definitions for the vmul lane multiplier: op encoding and the
// per-op operand extension rules.
package vmul_pkg;

  typedef logic [1:0] vmul_op_t;

  localparam vmul_op_t VMUL_MUL    = 2'b00;
  localparam vmul_op_t VMUL_MULH   = 2'b01;
  localparam vmul_op_t VMUL_MULHSU = 2'b10;
  localparam vmul_op_t VMUL_MULHU  = 2'b11;

  // Returns {a_signed, b_signed}; MUL uses zero extension since its low half is sign-agnostic.
  function automatic logic [1:0] vmul_ext_signs(input vmul_op_t op);
    logic [1:0] s;
    s = 2'b00;
    case (op)
      VMUL_MULH:   s = 2'b11;
      VMUL_MULHSU: s = 2'b10;
      default:     s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vmul_booth_pp.sv
// Radix-4 Booth encoder: turns a (WIDTH+1)-bit signed multiplier into WIDTH/2+1
// signed partial-product rows, each pre-shifted and sign-extended to 2*WIDTH bits.
module vmul_booth_pp
  import vmul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]                  i_mcand,
  input  logic [WIDTH:0]                  i_mplier,
  output logic [WIDTH/2:0][2*WIDTH-1:0]   o_pp
);

  localparam int ROWS = WIDTH/2 + 1;
  localparam int PW   = 2*WIDTH;

  logic [WIDTH+2:0] w_y;
  logic [PW-1:0]    w_a1;
  logic [PW-1:0]    w_a2;

  // One extra sign bit on top gives an even digit count; the zero at the bottom is y[-1].
  assign w_y  = {i_mplier[WIDTH], i_mplier, 1'b0};
  assign w_a1 = {{(PW-WIDTH-1){i_mcand[WIDTH]}}, i_mcand};
  assign w_a2 = w_a1 << 1;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [2:0]    w_bits;
      logic          w_one;
      logic          w_two;
      logic          w_neg;
      logic [PW-1:0] w_mag;
      logic [PW-1:0] w_sgn;

      assign w_bits = w_y[2*gi+2 : 2*gi];
      assign w_neg  = w_bits[2];
      assign w_one  = w_bits[1] ^ w_bits[0];
      assign w_two  = (w_bits == 3'b100) | (w_bits == 3'b011);
      assign w_mag  = w_one ? w_a1 : (w_two ? w_a2 : '0);
      assign w_sgn  = w_neg ? (~w_mag + PW'(1)) : w_mag;
      assign o_pp[gi] = w_sgn << (2*gi);
    end
  endgenerate

endmodule

// File: rtl/vmul_pipe.sv
// Pipelined RISC-V M-extension multiplier lane: Booth rows and carry-save
// reduction feed STAGES valid/ready register slices, last slice holds the result.
module vmul_pipe
  import vmul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ROWS = WIDTH/2 + 1;
  localparam int PW   = 2*WIDTH;

  logic [1:0]                 w_sign;
  logic [WIDTH:0]             w_a_ext;
  logic [WIDTH:0]             w_b_ext;
  logic [WIDTH/2:0][PW-1:0]   w_pp;
  logic [PW-1:0]              w_cs_s [1:ROWS-1];
  logic [PW-1:0]              w_cs_c [1:ROWS-1];

  logic [STAGES-1:0]          w_vld;
  logic [STAGES-1:0]          w_rdy;
  logic [STAGES-1:0]          w_in_vld;
  logic [PW-1:0]              w_in_sum [STAGES];
  logic [PW-1:0]              w_in_car [STAGES];
  vmul_op_t                   w_in_op  [STAGES];
  logic [TAG_W-1:0]           w_in_tag [STAGES];

  assign w_sign  = vmul_ext_signs(vmul_op_t'(in_op));
  assign w_a_ext = {w_sign[1] & in_a[WIDTH-1], in_a};
  assign w_b_ext = {w_sign[0] & in_b[WIDTH-1], in_b};

  vmul_booth_pp #(.WIDTH(WIDTH)) u_booth (
    .i_mcand  (w_a_ext),
    .i_mplier (w_b_ext),
    .o_pp     (w_pp)
  );

  // Carry-save chain: every row after the first two is folded in by one 3:2 level.
  assign w_cs_s[1] = w_pp[0];
  assign w_cs_c[1] = w_pp[1];

  generate
    for (genvar gi = 2; gi < ROWS; gi++) begin : g_csa
      logic [PW-1:0] w_maj;
      assign w_cs_s[gi] = w_cs_s[gi-1] ^ w_cs_c[gi-1] ^ w_pp[gi];
      assign w_maj      = (w_cs_s[gi-1] & w_cs_c[gi-1]) |
                          (w_cs_s[gi-1] & w_pp[gi]) |
                          (w_cs_c[gi-1] & w_pp[gi]);
      assign w_cs_c[gi] = w_maj << 1;
    end
  endgenerate

  // A slice may load when it or any slice downstream of it is empty, or the consumer takes.
  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        w_rdy[k] = w_rdy[k] | ~w_vld[j];
      end
    end
  end

  assign in_ready    = w_rdy[0] & ~flush;
  assign w_in_vld[0] = in_valid & in_ready;
  assign w_in_sum[0] = w_cs_s[ROWS-1];
  assign w_in_car[0] = w_cs_c[ROWS-1];
  assign w_in_op[0]  = vmul_op_t'(in_op);
  assign w_in_tag[0] = in_tag;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi < STAGES-1) begin : g_mid
        logic             r_vld;
        logic [PW-1:0]    r_sum;
        logic [PW-1:0]    r_car;
        vmul_op_t         r_op;
        logic [TAG_W-1:0] r_tag;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_vld <= 1'b0;
            r_sum <= '0;
            r_car <= '0;
            r_op  <= VMUL_MUL;
            r_tag <= '0;
          end else begin
            if (flush)
              r_vld <= 1'b0;
            else if (w_rdy[gi])
              r_vld <= w_in_vld[gi];
            if (w_rdy[gi] && w_in_vld[gi]) begin
              r_sum <= w_in_sum[gi];
              r_car <= w_in_car[gi];
              r_op  <= w_in_op[gi];
              r_tag <= w_in_tag[gi];
            end
          end
        end

        assign w_vld[gi]      = r_vld;
        assign w_in_vld[gi+1] = r_vld;
        assign w_in_sum[gi+1] = r_sum;
        assign w_in_car[gi+1] = r_car;
        assign w_in_op[gi+1]  = r_op;
        assign w_in_tag[gi+1] = r_tag;
      end else begin : g_last
        logic             r_vld;
        logic [WIDTH-1:0] r_res;
        logic [TAG_W-1:0] r_tag;
        logic [PW-1:0]    w_prod;
        logic [WIDTH-1:0] w_sel;

        // Final carry-propagate add sits in front of the output register.
        assign w_prod = w_in_sum[gi] + w_in_car[gi];
        assign w_sel  = (w_in_op[gi] == VMUL_MUL) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_vld <= 1'b0;
            r_res <= '0;
            r_tag <= '0;
          end else begin
            if (flush)
              r_vld <= 1'b0;
            else if (w_rdy[gi])
              r_vld <= w_in_vld[gi];
            if (w_rdy[gi] && w_in_vld[gi]) begin
              r_res <= w_sel;
              r_tag <= w_in_tag[gi];
            end
          end
        end

        assign w_vld[gi]  = r_vld;
        assign out_valid  = r_vld;
        assign out_result = r_res;
        assign out_tag    = r_tag;
      end
    end
  endgenerate

endmodule
